// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the word PC, issues 1-cycle-latency imem reads and hands
// {instr, pc} to decode over valid/ready, with a 1-entry skid for stalls.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_valid,
  input  logic                  dec_ready,
  input  logic                  jump,
  input  logic [31:0]           jump_address,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_offset,
  input  logic [ADDR_WIDTH-1:0] branch_pc,
  output logic                  halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, tag_pc, skid_pc, target;
  logic [31:0]           skid_instr;
  logic                  inflight, skid_vld;
  logic                  redirect, in_range, can_load, issue;

  assign in_range = 64'(pc_q) < 64'(IMEM_DEPTH);
  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_address[ADDR_WIDTH-1:0]
                         : branch_pc + ADDR_WIDTH'(1) + branch_offset[ADDR_WIDTH-1:0];
  assign can_load = !if_valid | dec_ready;
  // Only issue when the return is guaranteed a home (output or empty skid).
  assign issue    = (state_q == RUN) && in_range && !skid_vld && (!inflight || can_load);

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = RUN;
    else if (state_q == RUN && !in_range)
      state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      tag_pc     <= '0;
      inflight   <= 1'b0;
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        // Any read issued before or during this cycle is wrong-path and dropped.
        pc_q     <= target;
        inflight <= 1'b0;
        skid_vld <= 1'b0;
        if_valid <= 1'b0;
        if_instr <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc_q   <= pc_q + ADDR_WIDTH'(1);
          tag_pc <= pc_q;
        end
        if (skid_vld) begin
          if (can_load) begin
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            if_valid <= 1'b1;
            skid_vld <= 1'b0;
          end
        end else if (inflight) begin
          if (can_load) begin
            if_instr <= imem_rdata;
            if_pc    <= tag_pc;
            if_valid <= 1'b1;
          end else begin
            skid_instr <= imem_rdata;
            skid_pc    <= tag_pc;
            skid_vld   <= 1'b1;
          end
        end else if (dec_ready) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// checked against an expected-PC-stream model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        dec_ready, jump, branch_taken;
  logic [31:0] jump_address, branch_offset, branch_pc;
  logic [31:0] rdata_b, rdata_s;

  logic        req_b, valid_b, halted_b;
  logic [31:0] addr_b, instr_b, pc_b;
  logic        req_s, valid_s, halted_s;
  logic [31:0] addr_s, instr_s, pc_s;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_b <= mem[addr_b[7:0]];
    rdata_s <= mem[addr_s[7:0]];
  end

  instruction_fetch_unit #(.ADDR_WIDTH(32), .IMEM_DEPTH(256), .RESET_PC(32'd0)) u_big (
    .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .if_instr(instr_b), .if_pc(pc_b), .if_valid(valid_b), .dec_ready(dec_ready),
    .jump(jump), .jump_address(jump_address), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .branch_pc(branch_pc), .halted(halted_b));

  instruction_fetch_unit #(.ADDR_WIDTH(32), .IMEM_DEPTH(4), .RESET_PC(32'd0)) u_small (
    .clk(clk), .reset(reset), .imem_req(req_s), .imem_addr(addr_s), .imem_rdata(rdata_s),
    .if_instr(instr_s), .if_pc(pc_s), .if_valid(valid_s), .dec_ready(dec_ready),
    .jump(jump), .jump_address(jump_address), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .branch_pc(branch_pc), .halted(halted_s));

  task automatic do_reset();
    reset = 1'b1; dec_ready = 1'b1; jump = 1'b0; branch_taken = 1'b0;
    jump_address = '0; branch_offset = '0; branch_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dec_ready = 1'b1; jump = 1'b0; branch_taken = 1'b0;
    jump_address = '0; branch_offset = '0; branch_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_b); end
    checks++; if (instr_b !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_b); end
    checks++; if (pc_b !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_b); end
    checks++; if (halted_b !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted_b); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL first_cycle_valid got=%b exp=0", valid_b); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid_b !== 1'b1 || pc_b !== 32'(i) || instr_b !== mem[i]) begin
        failures++;
        $display("FAIL stream_%0d got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h", i, valid_b, pc_b, instr_b, i, mem[i]);
      end
    end
  endtask

  task automatic test_stall();
    int exp_pc;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (pc_b !== 32'd1 || valid_b !== 1'b1) begin failures++; $display("FAIL stall_pre got pc=%h v=%b exp pc=1 v=1", pc_b, valid_b); end
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid_b !== 1'b1 || pc_b !== 32'd1 || instr_b !== mem[1] || req_b !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h ins=%h req=%b exp v=1 pc=1 ins=%h req=0", i, valid_b, pc_b, instr_b, req_b, mem[1]);
      end
    end
    dec_ready = 1'b1;
    exp_pc = 2;
    for (int i = 0; i < 10 && exp_pc < 5; i++) begin
      @(negedge clk);
      if (valid_b) begin
        checks++;
        if (pc_b !== 32'(exp_pc) || instr_b !== mem[exp_pc]) begin
          failures++;
          $display("FAIL stall_release got pc=%h ins=%h exp pc=%h ins=%h", pc_b, instr_b, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
      end
    end
    checks++; if (exp_pc != 5) begin failures++; $display("FAIL stall_release_timeout got=%0d exp=5", exp_pc); end
  endtask

  task automatic test_jump();
    bit seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = valid_b && pc_b == 32'd2;
    end
    checks++; if (!seen) begin failures++; $display("FAIL jump_wait got=0 exp=1"); end
    jump = 1'b1; jump_address = 32'h10;
    @(negedge clk);
    jump = 1'b0;
    checks++; if (valid_b !== 1'b0 || instr_b !== 32'd0) begin failures++; $display("FAIL jump_flush got v=%b ins=%h exp v=0 ins=0", valid_b, instr_b); end
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); seen = valid_b; end
      checks++;
      if (!seen || pc_b !== 32'h10 + 32'(k) || instr_b !== mem[8'h10 + 8'(k)]) begin
        failures++;
        $display("FAIL jump_target_%0d got v=%b pc=%h ins=%h exp pc=%h", k, seen, pc_b, instr_b, 32'h10 + 32'(k));
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_t [2];
    bit seen;
    exp_t[0] = 32'd3; exp_t[1] = 32'd8;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      repeat (3) @(negedge clk);
      branch_taken = 1'b1; branch_pc = 32'd5; branch_offset = 32'hFFFF_FFFD;
      jump = (k == 1); jump_address = 32'd8;
      @(negedge clk);
      branch_taken = 1'b0; jump = 1'b0;
      checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL branch_flush_%0d got=%b exp=0", k, valid_b); end
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); seen = valid_b; end
      checks++;
      if (!seen || pc_b !== exp_t[k] || instr_b !== mem[exp_t[k][7:0]]) begin
        failures++;
        $display("FAIL branch_target_%0d got v=%b pc=%h exp pc=%h", k, seen, pc_b, exp_t[k]);
      end
    end
  endtask

  task automatic test_halt();
    int exp_pc;
    bit seen;
    do_reset();
    exp_pc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_s) begin
        checks++;
        if (pc_s !== 32'(exp_pc) || instr_s !== mem[exp_pc]) begin
          failures++; $display("FAIL halt_stream got pc=%h exp pc=%h", pc_s, exp_pc);
        end
        exp_pc++;
      end
      if (i >= 8) begin
        checks++;
        if (halted_s !== 1'b1 || req_s !== 1'b0) begin
          failures++; $display("FAIL halt_state_%0d got halted=%b req=%b exp halted=1 req=0", i, halted_s, req_s);
        end
      end
    end
    checks++; if (exp_pc != 4) begin failures++; $display("FAIL halt_count got=%0d exp=4", exp_pc); end
    jump = 1'b1; jump_address = 32'd1;
    @(negedge clk);
    jump = 1'b0;
    checks++; if (halted_s !== 1'b0) begin failures++; $display("FAIL halt_resume got=%b exp=0", halted_s); end
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); seen = valid_s; end
    checks++;
    if (!seen || pc_s !== 32'd1 || instr_s !== mem[1]) begin
      failures++; $display("FAIL halt_resume_pc got v=%b pc=%h exp pc=1", seen, pc_s);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) @(negedge clk);
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_b !== 1'b0 || instr_b !== 32'd0 || pc_b !== 32'd0 || halted_b !== 1'b0) begin
      failures++; $display("FAIL midreset_state got v=%b ins=%h pc=%h h=%b exp all 0", valid_b, instr_b, pc_b, halted_b);
    end
    reset = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL midreset_no_valid got=%b exp=0", valid_b); end
    @(negedge clk);
    checks++;
    if (valid_b !== 1'b1 || pc_b !== 32'd0 || instr_b !== mem[0]) begin
      failures++; $display("FAIL midreset_restart got v=%b pc=%h exp v=1 pc=0", valid_b, pc_b);
    end
  endtask

  // Model: the decoder must see mem[p], mem[p+1], ... from the last redirect
  // target, with stalled outputs held and a flush after every redirect.
  task automatic test_random();
    logic [31:0] exp_pc, p_instr, p_pc, ja, bpc, boff;
    bit p_valid, p_ready, p_redir, rdy, jmp, br;
    int r, n_xfer;
    do_reset();
    exp_pc = 0; n_xfer = 0;
    p_valid = 0; p_ready = 1; p_redir = 0; p_instr = '0; p_pc = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (p_redir) begin
        checks++;
        if (valid_b !== 1'b0 || instr_b !== 32'd0) begin
          failures++; $display("FAIL rand_flush cyc=%0d got v=%b ins=%h exp v=0 ins=0", cyc, valid_b, instr_b);
        end
      end else if (p_valid && !p_ready) begin
        checks++;
        if (valid_b !== 1'b1 || instr_b !== p_instr || pc_b !== p_pc) begin
          failures++; $display("FAIL rand_hold cyc=%0d got v=%b pc=%h exp v=1 pc=%h", cyc, valid_b, pc_b, p_pc);
        end
      end
      rdy = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      jmp = (r < 4);
      br = (r >= 2 && r < 7);
      ja = 32'($urandom_range(0, 200));
      bpc = 32'($urandom_range(0, 200));
      boff = 32'($urandom_range(0, 31)) - 32'd16;
      dec_ready = rdy; jump = jmp; jump_address = ja;
      branch_taken = br; branch_pc = bpc; branch_offset = boff;
      if (valid_b && rdy) begin
        checks++;
        if (pc_b !== exp_pc || instr_b !== mem[exp_pc[7:0]]) begin
          failures++; $display("FAIL rand_xfer cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h", cyc, pc_b, instr_b, exp_pc, mem[exp_pc[7:0]]);
        end
        exp_pc++;
        n_xfer++;
      end
      if (jmp) exp_pc = ja;
      else if (br) exp_pc = bpc + 32'd1 + boff;
      p_redir = jmp || br;
      p_valid = valid_b; p_ready = rdy; p_instr = instr_b; p_pc = pc_b;
    end
    jump = 1'b0; branch_taken = 1'b0; dec_ready = 1'b1;
    checks++; if (n_xfer <= 100) begin failures++; $display("FAIL rand_progress got=%0d exp>100", n_xfer); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom() | 32'h1;
    test_reset();
    test_stall();
    test_jump();
    test_branch();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
